sobel_job_sequencer: RTL and testbench

- Wishbone master that programs and sequences the sobel edge-detection slave across a queue of frame jobs.
- A job is one (source image base, destination image base) pair.
- It writes the interrupt enable, both base registers and start, then waits for int_req. It reads the status register to clear done, reports completion and launches the next queued job.
- Sits between the CPU/host job interface and the sobel slave port, so software need not babysit each frame.

---
 rtl/sobel_pkg.sv | 36 +++
 rtl/sobel_job_fifo.sv | 68 ++++++
 rtl/sobel_job_sequencer.sv | 165 ++++++++++++++++
 tb/tb_sobel_job_sequencer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared definitions for the sobel job sequencer: slave register map,
// sequencer state encoding and frame geometry.
package sobel_pkg;

  // Sobel slave register select values
  localparam logic [1:0] SOBEL_ADR_CTRL  = 2'd0;
  localparam logic [1:0] SOBEL_ADR_START = 2'd1;
  localparam logic [1:0] SOBEL_ADR_OBASE = 2'd2;
  localparam logic [1:0] SOBEL_ADR_DBASE = 2'd3;

  // Frame geometry processed by the slave per job
  localparam int IMG_WIDTH       = 640;
  localparam int IMG_HEIGHT      = 480;
  localparam int PIX_PER_WORD    = 4;
  localparam int WORDS_PER_FRAME = IMG_WIDTH * IMG_HEIGHT / PIX_PER_WORD;

  // Job width held in the queue: {src[21:0], dst[21:0]}
  localparam int JOB_W = 44;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WR_CTRL   = 3'd1,
    ST_WR_OBASE  = 3'd2,
    ST_WR_DBASE  = 3'd3,
    ST_WR_START  = 3'd4,
    ST_WAIT_DONE = 3'd5,
    ST_RD_STAT   = 3'd6,
    ST_COMPLETE  = 3'd7
  } seq_state_e;

  // Word-aligned base register value; byte offset bits are dropped
  function automatic logic [31:0] base_word(input logic [19:0] word_addr);
    return {10'b0, word_addr, 2'b00};
  endfunction

endpackage

// File: rtl/sobel_job_fifo.sv
// Synchronous job queue with full/empty/level. Pushes while full and pops
// while empty are ignored. The head entry is visible combinationally so the
// sequencer can latch it on the pop edge.
module sobel_job_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 44,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LW-1:0]    level_o
);

  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             push_ok, pop_ok;

  assign full_o  = (level_q == FULL_LVL);
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Pointer and occupancy update; depth is a power of two so pointers wrap
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Storage array, no reset so it can map onto RAM
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Control registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/sobel_job_sequencer.sv
// Wishbone master that pulls (src, dst) jobs from a queue, programs the
// sobel slave, waits for its interrupt, clears done via a status read and
// reports completion.
module sobel_job_sequencer
  import sobel_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int CNT_W          = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          enable_i,
  input  logic                          job_valid_i,
  output logic                          job_ready_o,
  input  logic [21:0]                   job_src_i,
  input  logic [21:0]                   job_dst_i,
  output logic                          cyc_o,
  output logic                          stb_o,
  output logic                          we_o,
  output logic [1:0]                    adr_o,
  output logic [31:0]                   dat_o,
  input  logic [31:0]                   dat_i,
  input  logic                          ack_i,
  input  logic                          int_req_i,
  output logic                          busy_o,
  output logic                          job_done_o,
  output logic [CNT_W-1:0]              done_cnt_o,
  output logic                          timeout_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES);

  seq_state_e       state_q, state_d;
  logic [21:0]      cur_src_q, cur_src_d;
  logic [21:0]      cur_dst_q, cur_dst_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] done_cnt_q, done_cnt_d;
  logic             fifo_pop, fifo_full, fifo_empty;
  logic [JOB_W-1:0] fifo_rdata;
  logic             waiting;
  logic             unused_bits;

  // Byte offsets and the upper status bits carry no information here
  assign unused_bits = ^{cur_src_q[1:0], cur_dst_q[1:0], dat_i[31:1]};

  // Ready is held low while reset is applied so nothing is accepted then
  assign job_ready_o = !fifo_full && !rst_i;
  assign busy_o      = (state_q != ST_IDLE);
  assign done_cnt_o  = done_cnt_q;
  assign timeout_o   = timeout_q;
  assign stb_o       = cyc_o;
  assign waiting     = (state_q == ST_WAIT_DONE) || (state_q == ST_RD_STAT);

  sobel_job_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (JOB_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (job_valid_i && job_ready_o),
    .wdata_i ({job_src_i, job_dst_i}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level_o)
  );

  // Next state, Moore bus outputs, watchdog and completion bookkeeping
  always_comb begin
    state_d    = state_q;
    cur_src_d  = cur_src_q;
    cur_dst_d  = cur_dst_q;
    wd_d       = wd_q;
    timeout_d  = timeout_q;
    done_cnt_d = done_cnt_q;
    fifo_pop   = 1'b0;
    cyc_o      = 1'b0;
    we_o       = 1'b0;
    adr_o      = SOBEL_ADR_CTRL;
    dat_o      = 32'd0;
    job_done_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable_i && !fifo_empty) begin
          fifo_pop  = 1'b1;
          cur_src_d = fifo_rdata[43:22];
          cur_dst_d = fifo_rdata[21:0];
          state_d   = ST_WR_CTRL;
        end
      end
      ST_WR_CTRL: begin
        cyc_o = 1'b1;
        we_o  = 1'b1;
        adr_o = SOBEL_ADR_CTRL;
        dat_o = 32'd1;
        if (ack_i) state_d = ST_WR_OBASE;
      end
      ST_WR_OBASE: begin
        cyc_o = 1'b1;
        we_o  = 1'b1;
        adr_o = SOBEL_ADR_OBASE;
        dat_o = base_word(cur_src_q[21:2]);
        if (ack_i) state_d = ST_WR_DBASE;
      end
      ST_WR_DBASE: begin
        cyc_o = 1'b1;
        we_o  = 1'b1;
        adr_o = SOBEL_ADR_DBASE;
        dat_o = base_word(cur_dst_q[21:2]);
        if (ack_i) state_d = ST_WR_START;
      end
      ST_WR_START: begin
        cyc_o = 1'b1;
        we_o  = 1'b1;
        adr_o = SOBEL_ADR_START;
        if (ack_i) begin
          state_d = ST_WAIT_DONE;
          wd_d    = '0;
        end
      end
      ST_WAIT_DONE: begin
        if (int_req_i) state_d = ST_RD_STAT;
      end
      ST_RD_STAT: begin
        cyc_o = 1'b1;
        adr_o = SOBEL_ADR_CTRL;
        if (ack_i) state_d = dat_i[0] ? ST_COMPLETE : ST_WAIT_DONE;
      end
      ST_COMPLETE: begin
        job_done_o = 1'b1;
        done_cnt_d = done_cnt_q + CNT_W'(1);
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Watchdog keeps running through spurious status reads and saturates
    if (waiting && wd_q != WD_MAX) wd_d = wd_q + WD_W'(1);
    if (waiting && wd_d == WD_MAX) timeout_d = 1'b1;
  end

  // State and datapath registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      cur_src_q  <= '0;
      cur_dst_q  <= '0;
      wd_q       <= '0;
      timeout_q  <= 1'b0;
      done_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cur_src_q  <= cur_src_d;
      cur_dst_q  <= cur_dst_d;
      wd_q       <= wd_d;
      timeout_q  <= timeout_d;
      done_cnt_q <= done_cnt_d;
    end
  end

endmodule

// File: tb/tb_sobel_job_sequencer.sv
// Directed bench for sobel_job_sequencer with a behavioural sobel slave.
module tb_sobel_job_sequencer;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        enable_i;
  logic        job_valid_i;
  logic        job_ready_o;
  logic [21:0] job_src_i;
  logic [21:0] job_dst_i;
  logic        cyc_o, stb_o, we_o;
  logic [1:0]  adr_o;
  logic [31:0] dat_o;
  logic [31:0] dat_i;
  logic        ack_i;
  logic        int_req_i;
  logic        busy_o;
  logic        job_done_o;
  logic [15:0] done_cnt_o;
  logic        timeout_o;
  logic [2:0]  fifo_level_o;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  sobel_job_sequencer #(
    .FIFO_DEPTH     (4),
    .TIMEOUT_CYCLES (50),
    .CNT_W          (16)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .enable_i     (enable_i),
    .job_valid_i  (job_valid_i),
    .job_ready_o  (job_ready_o),
    .job_src_i    (job_src_i),
    .job_dst_i    (job_dst_i),
    .cyc_o        (cyc_o),
    .stb_o        (stb_o),
    .we_o         (we_o),
    .adr_o        (adr_o),
    .dat_o        (dat_o),
    .dat_i        (dat_i),
    .ack_i        (ack_i),
    .int_req_i    (int_req_i),
    .busy_o       (busy_o),
    .job_done_o   (job_done_o),
    .done_cnt_o   (done_cnt_o),
    .timeout_o    (timeout_o),
    .fifo_level_o (fifo_level_o)
  );

  // ---------------- behavioural sobel slave ----------------
  logic        ack_q;
  logic [31:0] rdat_q;
  logic        int_en_q, done_q;
  logic        spur;
  int          run_cnt;
  int          done_delay;
  int          rd_cnt = 0;
  int          pulses = 0;
  logic [33:0] wr_log [$];

  assign ack_i     = ack_q;
  assign dat_i     = rdat_q;
  assign int_req_i = (int_en_q && done_q) || spur;

  always @(posedge clk) begin
    if (rst_i) begin
      ack_q    <= 1'b0;
      rdat_q   <= 32'd0;
      int_en_q <= 1'b0;
      done_q   <= 1'b0;
      run_cnt  <= -1;
    end else begin
      ack_q <= cyc_o && stb_o && !ack_q;
      if (run_cnt > 0) run_cnt <= run_cnt - 1;
      else if (run_cnt == 0) begin
        done_q  <= 1'b1;
        run_cnt <= -1;
      end
      if (cyc_o && stb_o && !ack_q) begin
        if (we_o) begin
          wr_log.push_back({adr_o, dat_o});
          if (adr_o == 2'd0) int_en_q <= dat_o[0];
          if (adr_o == 2'd1) run_cnt <= done_delay;
        end else begin
          rdat_q <= {31'd0, done_q};
          rd_cnt <= rd_cnt + 1;
          if (adr_o == 2'd0) done_q <= 1'b0;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (job_done_o) pulses <= pulses + 1;
  end

  // ---------------- job table with hand-computed base words ----------------
  logic [21:0] q_src   [5] = '{22'h010000, 22'h3FFFFF, 22'h000005, 22'h123457, 22'h200002};
  logic [31:0] q_src_w [5] = '{32'h00010000, 32'h003FFFFC, 32'h00000004, 32'h00123454, 32'h00200000};
  logic [21:0] q_dst   [5] = '{22'h080000, 22'h000003, 22'h2AAAAA, 22'h155555, 22'h0ABCDE};
  logic [31:0] q_dst_w [5] = '{32'h00080000, 32'h00000000, 32'h002AAAA8, 32'h00155554, 32'h000ABCDC};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got === exp) begin
      pass_cnt++;
      $display("ok   %s got=%0h", tag, got);
    end else begin
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [33:0] log_at(input int i);
    if (i < wr_log.size()) return wr_log[i];
    return '1;
  endfunction

  task automatic check_job(input string tag, input int j, input logic [31:0] sw, input logic [31:0] dw);
    check({tag, "_ctrl"},  log_at(4*j),     {2'd0, 32'h00000001});
    check({tag, "_obase"}, log_at(4*j + 1), {2'd2, sw});
    check({tag, "_dbase"}, log_at(4*j + 2), {2'd3, dw});
    check({tag, "_start"}, log_at(4*j + 3), {2'd1, 32'h00000000});
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge
  task automatic push(input logic [21:0] s, input logic [21:0] d);
    int n = 0;
    job_valid_i = 1'b1;
    job_src_i   = s;
    job_dst_i   = d;
    while (!job_ready_o && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) check("push_wait", 0, 1);
    @(negedge clk);
    job_valid_i = 1'b0;
  endtask

  task automatic wait_jobs(input int target, input int budget);
    int n = 0;
    while (pulses < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (pulses < target) check("wait_jobs_budget", pulses, target);
  endtask

  task automatic wait_log(input int target, input int budget);
    int n = 0;
    while (wr_log.size() < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (wr_log.size() < target) check("wait_log_budget", wr_log.size(), target);
  endtask

  initial begin
    int base;
    int base_rd;
    int n;
    rst_i = 1'b1; enable_i = 1'b0; job_valid_i = 1'b0;
    job_src_i = '0; job_dst_i = '0; spur = 1'b0; done_delay = 20;

    // ---- reset state ----
    repeat (3) @(negedge clk);
    check("rst_cyc", cyc_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_job_done", job_done_o, 0);
    check("rst_done_cnt", done_cnt_o, 0);
    check("rst_timeout", timeout_o, 0);
    check("rst_level", fifo_level_o, 0);
    check("rst_ready_during", job_ready_o, 0);
    rst_i = 1'b0;
    @(negedge clk);
    check("rst_ready_after", job_ready_o, 1);

    // ---- single job ----
    enable_i = 1'b1; done_delay = 40; wr_log.delete();
    push(q_src[0], q_dst[0]);
    check("t1_level_pushed", fifo_level_o, 1);
    check("t1_idle_pushed", busy_o, 0);
    @(negedge clk);
    check("t1_popped_busy", busy_o, 1);
    check("t1_popped_level", fifo_level_o, 0);
    check("t1_ctrl_bus", {cyc_o, stb_o, we_o, adr_o, dat_o}, {3'b111, 2'd0, 32'd1});
    wait_jobs(1, 400);
    check("t1_pulses", pulses, 1);
    check("t1_done_cnt", done_cnt_o, 1);
    check("t1_log_size", wr_log.size(), 4);
    check_job("t1", 0, 32'h00010000, 32'h00080000);
    @(negedge clk);
    check("t1_idle", busy_o, 0);

    // ---- queue of five ----
    done_delay = 20; wr_log.delete(); base = pulses;
    for (int j = 0; j < 5; j++) push(q_src[j], q_dst[j]);
    check("t2_level_full", fifo_level_o, 4);
    check("t2_ready_low", job_ready_o, 0);
    wait_jobs(base + 5, 3000);
    check("t2_done_cnt", done_cnt_o, 6);
    check("t2_log_size", wr_log.size(), 20);
    for (int j = 0; j < 5; j++) check_job($sformatf("t2_job%0d", j), j, q_src_w[j], q_dst_w[j]);
    check("t2_level_empty", fifo_level_o, 0);

    // ---- spurious interrupt ----
    done_delay = 30; wr_log.delete(); base = pulses;
    push(q_src[3], q_dst[3]);
    wait_log(4, 100);
    repeat (10) @(negedge clk);
    base_rd = rd_cnt;
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    repeat (6) @(negedge clk);
    check("t3_spur_read", rd_cnt, base_rd + 1);
    check("t3_spur_no_done", pulses, base);
    check("t3_spur_busy", busy_o, 1);
    check("t3_spur_bus_idle", cyc_o, 0);
    wait_jobs(base + 1, 300);
    check("t3_real_read", rd_cnt, base_rd + 2);
    check("t3_done_cnt", done_cnt_o, 7);
    check("t3_timeout_clear", timeout_o, 0);

    // ---- watchdog ----
    done_delay = 100; wr_log.delete(); base = pulses;
    push(q_src[1], q_dst[1]);
    wait_log(4, 100);
    repeat (50) @(negedge clk);
    check("t4_timeout_cycle49", timeout_o, 0);
    @(negedge clk);
    check("t4_timeout_cycle50", timeout_o, 1);
    wait_jobs(base + 1, 400);
    check("t4_done_cnt", done_cnt_o, 8);
    check("t4_timeout_sticky", timeout_o, 1);

    // ---- enable dropped mid-job ----
    done_delay = 20; wr_log.delete(); base = pulses;
    push(q_src[2], q_dst[2]);
    push(q_src[3], q_dst[3]);
    push(q_src[4], q_dst[4]);
    wait_log(2, 100);
    @(negedge clk);
    check("t5_in_dbase", {cyc_o, adr_o}, {1'b1, 2'd3});
    enable_i = 1'b0;
    wait_jobs(base + 1, 300);
    repeat (5) @(negedge clk);
    check("t5_idle", busy_o, 0);
    check("t5_level_kept", fifo_level_o, 2);
    check("t5_no_more_writes", wr_log.size(), 4);
    check("t5_done_cnt", done_cnt_o, 9);
    enable_i = 1'b1;
    wait_jobs(base + 3, 600);
    check("t5_resume_cnt", done_cnt_o, 11);
    check("t5_resume_level", fifo_level_o, 0);
    check_job("t5_job1", 1, q_src_w[3], q_dst_w[3]);

    // ---- reset during an access ----
    done_delay = 20; wr_log.delete();
    push(q_src[0], q_dst[0]);
    push(q_src[1], q_dst[1]);
    n = 0;
    while (!(cyc_o && adr_o == 2'd2) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t6_in_obase", {cyc_o, adr_o, ack_i}, {1'b1, 2'd2, 1'b0});
    rst_i = 1'b1;
    @(negedge clk);
    check("t6_cyc", cyc_o, 0);
    check("t6_busy", busy_o, 0);
    check("t6_level", fifo_level_o, 0);
    check("t6_done_cnt", done_cnt_o, 0);
    check("t6_timeout", timeout_o, 0);
    rst_i = 1'b0;
    @(negedge clk);
    check("t6_ready", job_ready_o, 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
